// File: rtl/clock_time_loader.sv
// clock_time_loader: replays a validated HH:MM + alarm-select load as reset/digit/go key sequences to the clock core
//   clk, resetn (sync, active-low)
//   req_valid/req_ready handshake; req_alarm_only, req_hour1/2, req_min1/2 (BCD), req_alarm_sel
//   busy, done (pulse), err (pulse on rejected request)
//   clk_rst_o / alarm_rst_o (reset pulse to core), go_o (load key), data_o (digit)
module clock_time_loader #(
   parameter int SETUP_CYCLES   = 2,
   parameter int PRESS_CYCLES   = 4,
   parameter int RELEASE_CYCLES = 4,
   parameter int RST_CYCLES     = 2
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_alarm_only,
   input  logic [3:0] req_hour1,
   input  logic [3:0] req_hour2,
   input  logic [3:0] req_min1,
   input  logic [3:0] req_min2,
   input  logic [1:0] req_alarm_sel,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic       clk_rst_o,
   output logic       alarm_rst_o,
   output logic       go_o,
   output logic [3:0] data_o
);
   typedef enum logic [2:0] {IDLE, RST, SETUP, PRESS, RELEASE, DONE} state_t;
   localparam logic [7:0] S_LD = 8'(SETUP_CYCLES - 1);
   localparam logic [7:0] P_LD = 8'(PRESS_CYCLES - 1);
   localparam logic [7:0] R_LD = 8'(RELEASE_CYCLES - 1);
   localparam logic [7:0] T_LD = 8'(RST_CYCLES - 1);
   state_t state, state_n;
   logic [2:0] field, field_n;
   logic [7:0] cnt, cnt_n;
   logic [3:0] h1, h2, m1, m2, fd;
   logic [1:0] sel;
   logic       ao, ao_n, accept, ok;
   assign accept = req_valid && req_ready;
   assign ok = req_alarm_only ||
               (req_hour1 <= 4'd2 && req_hour2 <= 4'd9 && req_min1 <= 4'd5 && req_min2 <= 4'd9 &&
                (req_hour1 != 4'd2 || req_hour2 <= 4'd3));
   // the alarm/full choice must be known on the acceptance edge to pick the reset output
   assign ao_n = accept ? req_alarm_only : ao;
   always_comb begin
      state_n = state;
      field_n = field;
      cnt_n   = (cnt != 8'd0) ? cnt - 8'd1 : cnt;
      case (state)
         IDLE:    if (accept && ok) begin
                     state_n = RST;
                     cnt_n   = T_LD;
                     field_n = req_alarm_only ? 3'd4 : 3'd0;
                  end
         RST:     if (cnt == 8'd0) begin state_n = SETUP; cnt_n = S_LD; end
         SETUP:   if (cnt == 8'd0) begin state_n = PRESS; cnt_n = P_LD; end
         PRESS:   if (cnt == 8'd0) begin state_n = RELEASE; cnt_n = R_LD; end
         RELEASE: if (cnt == 8'd0) begin
                     if (field == 3'd4) state_n = DONE;
                     else begin
                        state_n = SETUP;
                        cnt_n   = S_LD;
                        field_n = field + 3'd1;
                     end
                  end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
      fd = (field_n == 3'd0) ? h1 :
           (field_n == 3'd1) ? h2 :
           (field_n == 3'd2) ? m1 :
           (field_n == 3'd3) ? m2 : {2'b00, sel};
   end
   // outputs are registered from the next-state decode so they line up with the state they describe
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state       <= IDLE;
         field       <= 3'd0;
         cnt         <= 8'd0;
         ao          <= 1'b0;
         req_ready   <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         clk_rst_o   <= 1'b0;
         alarm_rst_o <= 1'b0;
         go_o        <= 1'b0;
         data_o      <= 4'd0;
      end else begin
         state       <= state_n;
         field       <= field_n;
         cnt         <= cnt_n;
         ao          <= ao_n;
         req_ready   <= state_n == IDLE;
         busy        <= state_n != IDLE;
         done        <= state_n == DONE;
         err         <= accept && !ok;
         clk_rst_o   <= state_n == RST && !ao_n;
         alarm_rst_o <= state_n == RST && ao_n;
         go_o        <= state_n == PRESS;
         data_o      <= (state_n == SETUP || state_n == PRESS || state_n == RELEASE) ? fd : 4'd0;
      end
   end
   always_ff @(posedge clk) begin
      if (accept) begin
         h1  <= req_hour1;
         h2  <= req_hour2;
         m1  <= req_min1;
         m2  <= req_min2;
         sel <= req_alarm_sel;
      end
   end
endmodule

// File: doc/clock_time_loader.md
# clock_time_loader

Sequencer that drives the time-setting interface of the alarm clock core from a single parallel request. A host supplies a BCD HH:MM value and an alarm select through a valid/ready handshake. The block validates the request, then replays the same reset, digit and key-press sequence a user would make on the board: reset pulse, then data held stable, then a `go` press and release for each field. It sits between a host (UART/command decoder) and the clock core's `go`/`data_in`/reset inputs, multiplexed with the board keys.

## Interface
- `SETUP_CYCLES`, 2, cycles `data_o` is stable before `go_o` rises (1..255)
- `PRESS_CYCLES`, 4, cycles `go_o` is held high per field (1..255)
- `RELEASE_CYCLES`, 4, cycles `go_o` is low after a press, with `data_o` still held (1..255)
- `RST_CYCLES`, 2, width of the clock-core reset pulse (1..255)

- `clk` in 1: system clock
- `resetn` in 1: reset, synchronous, active-low
- `req_valid` in 1: request present
- `req_ready` out 1: high only in IDLE
- `req_alarm_only` in 1: 1 = reload the alarm only; 0 = full time plus alarm load
- `req_hour1`, `req_hour2`, `req_min1`, `req_min2` in 4 each: BCD digits
- `req_alarm_sel` in 2: timer select 0..3 (15/30/45/60 s)
- `busy` out 1: high in any state other than IDLE
- `done` out 1: one-cycle pulse when a sequence completes
- `err` out 1: one-cycle pulse when a request is rejected
- `clk_rst_o` out 1: active-high full reset to the clock core
- `alarm_rst_o` out 1: active-high alarm-only reset to the clock core
- `go_o` out 1: active-high load key to the clock core
- `data_o` out 4: digit to the clock core

## Operation
- **States:** IDLE, RST, SETUP, PRESS, RELEASE, DONE. The block holds a field index 0..4 and an 8-bit phase counter.
- **Accept:** a request is accepted on a rising edge with `req_valid && req_ready`. All request fields are registered on acceptance.
- **Validation (full load only):**
  - each digit must be ≤9
  - `hour1` ≤2
  - if `hour1`==2, `hour2` ≤3
  - `min1` ≤5
- **Alarm-only requests:** time digits are ignored; the request is always valid.
- **Invalid request:**
  - `err`=1 for the cycle after acceptance.
  - The state stays IDLE.
  - No output other than `err` changes.
- **Full load:**
  - RST drives `clk_rst_o`=1.
  - Fields are then sent in order: hour1, hour2, min1, min2, {2'b00,alarm_sel}.
- **Alarm-only load:**
  - RST drives `alarm_rst_o`=1 instead.
  - Only the alarm field is sent, as field index 4.
- **Per field:**
  - SETUP: `data_o`=field, `go_o`=0.
  - PRESS: `go_o`=1.
  - RELEASE: `go_o`=0, `data_o` unchanged.
  - After RELEASE, the block moves to the next field's SETUP, or to DONE after field 4.
- **DONE:** `done`=1 for one cycle, then IDLE.
- **IDLE outputs:** `data_o`=0, `go_o`=0, both reset outputs 0.
- **Request edges:** `req_valid` edges while busy are ignored (no queue). The host retries after `req_ready`.

## Timing
- **Reset values:** `resetn` low at an edge sets state IDLE and forces all outputs low: `req_ready`=1 after release, `busy`=0, `done`=0, `err`=0, `clk_rst_o`=0, `alarm_rst_o`=0, `go_o`=0, `data_o`=0.
- **Reset mid-sequence:** the same values apply. The partial load is abandoned, not resumed, and `go_o` drops on that edge.
- **Output timing:** all outputs are registered. Cycle 0 is the acceptance edge.
- **RST duration:** RST lasts exactly RST_CYCLES cycles.
- **Field timing:** each field lasts exactly S+P+R cycles (SETUP_CYCLES + PRESS_CYCLES + RELEASE_CYCLES). `data_o` is stable for the whole S+P+R window.
- **Full load with defaults:**
  - reset outputs high in cycles 1–2
  - field k occupies cycles 3+10k .. 12+10k
  - `go_o` is high in cycles 5+10k .. 8+10k
  - `done` in cycle 53
  - `req_ready`=1 in cycle 54
- **Alarm-only with defaults:**
  - reset high in cycles 1–2
  - field in cycles 3–12
  - `done` in cycle 13
  - ready in cycle 14
- **General latency:** full load `done` cycle = 1 + RST_CYCLES + 5(S+P+R); alarm-only = 1 + RST_CYCLES + (S+P+R).
- **Invalid request:** `err` in cycle 1; `req_ready`=1 in cycle 1.
- **Mutual exclusion:** `done` and `err` never assert in the same cycle. `clk_rst_o` and `alarm_rst_o` are never high together.
- **Counter:** the phase counter reloads at every phase entry and never wraps. A parameter value of 1 gives a single-cycle phase.

## Test plan
- **Full load, defaults:** request 2,3,5,9, sel=2 → `clk_rst_o` high in cycles 1–2; `data_o` sequence 2,3,5,9,2, each stable 10 cycles; four-cycle `go_o` pulses starting at cycles 5,15,25,35,45; `done` at cycle 53.
- **Alarm-only:** sel=1 → `alarm_rst_o` high in cycles 1–2; `data_o`=1 in cycles 3–12; `go_o` high in cycles 5–8; `done` at cycle 13; `clk_rst_o` never high.
- **Invalid time:** request 2,4,0,0 and 1,0,6,0 → `err` pulse at cycle 1; `go_o`, `data_o` and the reset outputs stay 0; `req_ready` back to 1 at cycle 1.
- **Reset mid-sequence:** assert `resetn`=0 at cycle 27, during field 2 PRESS → every output 0 at the next edge; a new request after release starts cleanly from RST.
- **Backpressure:** hold `req_valid`=1 through a full load → exactly one sequence per `req_ready` window; a second request is accepted at cycle 54.
- **Parameter corners:** all parameters =1 → full load `done` at cycle 17; every `go_o` pulse is 1 cycle, preceded and followed by 1 low cycle with `data_o` stable.
